// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle for the sequential divider.
//   start    request pulse (sampled by the divider only while idle)
//   A, B     dividend / divisor, two's complement
//   Lo, Hi   quotient / remainder, registered in the divider
//   busy     divider is in RUN or FIX
//   done     one-cycle pulse, Lo/Hi freshly written
//   div_zero present only with DIV_SEQ_DIV_ZERO_FLAG_EN; pulses with done on B = 0
// Modports: master (control unit side), slave (divider side).
interface div_seq_if;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Lo;
   logic [31:0] Hi;
   logic        busy;
   logic        done;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
   logic        div_zero;
`endif

   modport master (
      output start, A, B,
      input  Lo, Hi, busy, done
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
      , input div_zero
`endif
   );

   modport slave (
      input  start, A, B,
      output Lo, Hi, busy, done
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
      , output div_zero
`endif
   );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential signed 32-bit divider, radix-2 restoring on magnitudes.
// Quotient returned on Lo, remainder on Hi (remainder takes the dividend's sign,
// quotient truncates toward zero). B = 0 forces Lo = 0xFFFFFFFF, Hi = A.
// Ports:
//   clock  rising-edge clock
//   clear  synchronous active-high reset
//   bus    div_seq_if.slave (start, A, B in; Lo, Hi, busy, done [, div_zero] out)
// Optional feature macro: DIV_SEQ_DIV_ZERO_FLAG_EN -- adds div_zero and a short
// path (IDLE -> FIX) for a zero divisor.
module div_seq (
   input  logic     clock,
   input  logic     clear,
   div_seq_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e      state_q, state_d;
   logic [31:0] dvd_q, dvd_d;      // dividend shift register, collects quotient bits
   logic [31:0] dsr_q, dsr_d;      // divisor magnitude
   logic [32:0] rem_q, rem_d;      // partial remainder
   logic [31:0] araw_q, araw_d;    // raw dividend for the divide-by-zero result
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        bzero_q, bzero_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        done_q, done_d;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
   logic        dz_q, dz_d;
`endif

   logic [31:0] abs_a, abs_b;
   logic [33:0] rem_sh;
   logic [33:0] trial;
   logic        q_bit;
   logic        accept;

   // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
   assign abs_a  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
   assign abs_b  = bus.B[31] ? (32'd0 - bus.B) : bus.B;
   assign accept = (state_q == StIdle) && bus.start;

   // One restoring step; trial[33] is the borrow/sign of the subtraction.
   assign rem_sh = {rem_q, dvd_q[31]};
   assign trial  = rem_sh - {2'b00, dsr_q};
   assign q_bit  = ~trial[33];

   // State register and datapath flops.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= StIdle;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         araw_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         bzero_q <= 1'b0;
         cnt_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         done_q  <= 1'b0;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         araw_q  <= araw_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         bzero_q <= bzero_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         done_q  <= done_d;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
         dz_q    <= dz_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
               state_d = (bus.B == 32'd0) ? StFix : StRun;
`else
               state_d = StRun;
`endif
            end
         end
         StRun:   if (cnt_q == 5'd31) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      araw_d  = araw_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      bzero_d = bzero_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      done_d  = 1'b0;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
      dz_d    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               dvd_d   = abs_a;
               dsr_d   = abs_b;
               rem_d   = '0;
               araw_d  = bus.A;
               qneg_d  = bus.A[31] ^ bus.B[31];
               rneg_d  = bus.A[31];
               bzero_d = (bus.B == 32'd0);
               cnt_d   = '0;
            end
         end
         StRun: begin
            rem_d = q_bit ? trial[32:0] : rem_sh[32:0];
            dvd_d = {dvd_q[30:0], q_bit};
            cnt_d = cnt_q + 5'd1;
         end
         StFix: begin
            if (bzero_q) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = araw_q;
            end else begin
               lo_d = qneg_q ? (32'd0 - dvd_q) : dvd_q;
               hi_d = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
            end
            done_d = 1'b1;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
            dz_d   = bzero_q;
`endif
         end
         default: ;
      endcase
   end

   // Outputs.
   always_comb begin
      bus.busy = (state_q == StRun) || (state_q == StFix);
      bus.Lo   = lo_q;
      bus.Hi   = hi_q;
      bus.done = done_q;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
      bus.div_zero = dz_q;
`endif
   end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq. The driver pushes the expected
// Lo/Hi and completion cycle for every accepted request; a negedge monitor pops
// and compares whenever done is seen. Reference results come from 64-bit signed
// arithmetic (SV / and % truncate toward zero, remainder follows the dividend).
module tb_div_seq;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      int          due;
      logic        dz;
   } exp_t;

   logic clock = 1'b0;
   logic clear;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   div_seq_if bus ();

   div_seq dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
      exp_t   e;
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      e.due = acc + 33;
      e.dz  = (b == 32'd0);
      if (b == 32'd0) begin
         e.lo = 32'hFFFF_FFFF;
         e.hi = a;
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
         e.due = acc + 1;
`endif
      end else begin
         e.lo = 32'(sa / sb);
         e.hi = 32'(sa % sb);
      end
      return e;
   endfunction

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clock) begin
      if (!clear && bus.done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("lo", bus.Lo, mon_e.lo);
            check("hi", bus.Hi, mon_e.hi);
            check("done_cycle", 32'(cyc), 32'(mon_e.due));
            check("busy_with_done", {31'd0, bus.busy}, 32'd0);
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
            check("div_zero", {31'd0, bus.div_zero}, {31'd0, mon_e.dz});
`endif
         end
      end
   end

   // Present one request for one edge and record its expectation.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(posedge clock);
      #1;
      exp_q.push_back(model(a, b, cyc));
      bus.start = 1'b0;
   endtask

   // Wait for the scoreboard to empty; optionally check the busy length.
   task automatic wait_drain(input int busy_exp);
      int n = 0;
      int busy_cnt = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clock);
         #1;
         if (bus.busy) busy_cnt++;
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      if (busy_exp >= 0) check("busy_len", 32'(busy_cnt), 32'(busy_exp));
   endtask

   initial begin
      logic [31:0] ra, rb;
      clear     = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_lo", bus.Lo, 32'd0);
      check("rst_hi", bus.Hi, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      clear = 1'b0;

      // Directed cases.
      issue(32'd100, 32'd7);                 wait_drain(33);
      issue(-32'sd100, 32'd7);               wait_drain(33);
      issue(32'd100, -32'sd7);               wait_drain(33);
      issue(32'h8000_0000, 32'hFFFF_FFFF);   wait_drain(33);
      issue(32'h8000_0000, 32'd1);           wait_drain(33);
`ifdef DIV_SEQ_DIV_ZERO_FLAG_EN
      issue(32'h1234_5678, 32'd0);           wait_drain(1);
`else
      issue(32'h1234_5678, 32'd0);           wait_drain(33);
`endif

      // start re-pulsed on edge N+10 is ignored.
      issue(32'd50, 32'd5);
      repeat (9) @(posedge clock);
      #1;
      bus.start = 1'b1;
      bus.A     = 32'd77;
      bus.B     = 32'd3;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      wait_drain(-1);

      // clear on edge N+20 abandons the operation; start on the same edge loses.
      issue(32'd1234, 32'd5);
      repeat (19) @(posedge clock);
      #1;
      clear     = 1'b1;
      bus.start = 1'b1;
      bus.A     = 32'd9;
      bus.B     = 32'd4;
      @(posedge clock);
      #1;
      clear     = 1'b0;
      bus.start = 1'b0;
      exp_q.delete();
      check("clr_busy", {31'd0, bus.busy}, 32'd0);
      check("clr_lo", bus.Lo, 32'd0);
      check("clr_hi", bus.Hi, 32'd0);
      check("clr_done", {31'd0, bus.done}, 32'd0);
      repeat (40) @(posedge clock);
      #1;
      check("clr_idle_busy", {31'd0, bus.busy}, 32'd0);
      issue(32'd9, 32'd4);                   wait_drain(33);

      // Back-to-back with start held high: accepts every 34 edges.
      @(negedge clock);
      bus.start = 1'b1;
      bus.A     = 32'd1000;
      bus.B     = 32'd3;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         exp_q.push_back(model(32'd1000, 32'd3, cyc));
         if (k < 2) repeat (33) @(posedge clock);
      end
      bus.start = 1'b0;
      wait_drain(-1);

      // Randomized operands, including zero and small divisors.
      for (int i = 0; i < 25; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'd0 - 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         issue(ra, rb);
         wait_drain(-1);
      end

      repeat (3) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
